// File: rtl/led_cfg_if.sv
// Configuration write port for led_channel_ctrl: a single-cycle strobe
// carrying the target channel and its mode/half-period/duty fields.
interface led_cfg_if #(
  parameter int CH_W  = 2,
  parameter int PER_W = 12,
  parameter int PWM_W = 8
);
  logic             CFG_WE;
  logic [CH_W-1:0]  CFG_CH;
  logic [1:0]       CFG_MODE;
  logic [PER_W-1:0] CFG_HALF;
  logic [PWM_W-1:0] CFG_DUTY;

  modport master (output CFG_WE, CFG_CH, CFG_MODE, CFG_HALF, CFG_DUTY);
  modport slave  (input  CFG_WE, CFG_CH, CFG_MODE, CFG_HALF, CFG_DUTY);
endinterface

// File: rtl/led_channel_ctrl.sv
// Multi-channel LED driver: shared tick prescaler and PWM counter feeding
// N_CH independent lanes, each OFF / ON / BLINK / PWM with a registered LED.
module led_lane #(
  parameter int PER_W = 12,
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [1:0]       mode_i,
  input  logic [PER_W-1:0] half_i,
  input  logic [PWM_W-1:0] duty_i,
  input  logic             tick_i,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  output logic             led_o
);
  typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_PWM = 2'd3} mode_e;

  mode_e            mode_q, mode_d;
  logic [PER_W-1:0] half_q, half_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             led_q, led_d;
  logic [PER_W-1:0] last_cnt;

  // half == 0 behaves as a one-tick half-period
  assign last_cnt = (half_q == '0) ? '0 : half_q - 1'b1;

  always_comb begin
    mode_d  = mode_q;
    half_d  = half_q;
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    // A write on a tick edge wins: the tick is not applied to this lane
    if (we_i) begin
      mode_d  = mode_e'(mode_i);
      half_d  = half_i;
      duty_d  = duty_i;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (tick_i && mode_q == M_BLINK) begin
      if (cnt_q == last_cnt) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      M_OFF:   led_d = 1'b0;
      M_ON:    led_d = 1'b1;
      M_BLINK: led_d = phase_q;
      M_PWM:   led_d = (pwm_cnt_i < duty_q);
      default: led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= M_OFF;
      half_q  <= '0;
      duty_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      half_q  <= half_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;
endmodule

module led_channel_ctrl #(
  parameter int CLK_HZ  = 27_000_000,
  parameter int TICK_HZ = 1000,
  parameter int N_CH    = 4,
  parameter int PER_W   = 12,
  parameter int PWM_W   = 8,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  led_cfg_if.slave        cfg,
  output logic            TICK,
  output logic [N_CH-1:0] LED
);
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = $clog2(DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  logic [PS_W-1:0]  ps_q, ps_d;
  logic             tick_q, tick_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic [N_CH-1:0]  we_lane;

  always_comb begin
    ps_d   = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
    // TICK is registered so it is high exactly while the prescaler sits at DIV-1
    tick_d = (ps_d == PS_LAST);
    pwm_d  = pwm_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
    end else begin
      ps_q   <= ps_d;
      tick_q <= tick_d;
      pwm_q  <= pwm_d;
    end
  end

  assign TICK = tick_q;

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_lane
      // Out-of-range channel indices match no lane and are dropped
      assign we_lane[i] = cfg.CFG_WE && (cfg.CFG_CH == CH_W'(i));

      led_lane #(
        .PER_W (PER_W),
        .PWM_W (PWM_W)
      ) u_lane (
        .clk       (CLK),
        .rst       (RST),
        .we_i      (we_lane[i]),
        .mode_i    (cfg.CFG_MODE),
        .half_i    (cfg.CFG_HALF),
        .duty_i    (cfg.CFG_DUTY),
        .tick_i    (tick_q),
        .pwm_cnt_i (pwm_q),
        .led_o     (LED[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_led_channel_ctrl.sv
// Bench for led_channel_ctrl: time-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_led_channel_ctrl;
  localparam int CLK_HZ = 1000, TICK_HZ = 100, N_CH = 4, PER_W = 4, PWM_W = 4;
  localparam int DIV = CLK_HZ / TICK_HZ;
  // Channel field is one bit wider than needed so an out-of-range index is expressible
  localparam int CH_W = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic TICK;
  logic [N_CH-1:0] LED;

  led_cfg_if #(.CH_W(CH_W), .PER_W(PER_W), .PWM_W(PWM_W)) cfg ();

  led_channel_ctrl #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_CH(N_CH),
    .PER_W(PER_W), .PWM_W(PWM_W), .CH_W(CH_W)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .cfg  (cfg),
    .TICK (TICK),
    .LED  (LED)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errs    = 0;

  // Reference model: blink phase derived from the number of ticks seen since
  // the last write, PWM from the edge count since reset release.
  int          m_n = 0;
  int          m_mode  [N_CH];
  int          m_half  [N_CH];
  int          m_duty  [N_CH];
  int          m_ticks [N_CH];
  logic [N_CH-1:0] exp_led  = '0;
  logic            exp_tick = 1'b0;

  initial begin
    for (int c = 0; c < N_CH; c++) begin
      m_mode[c] = 0; m_half[c] = 0; m_duty[c] = 0; m_ticks[c] = 0;
    end
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        m_n = 0;
        exp_led = '0;
        exp_tick = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
          m_mode[c] = 0; m_half[c] = 0; m_duty[c] = 0; m_ticks[c] = 0;
        end
      end else begin
        int pcnt, h;
        logic tick_in;
        m_n++;
        tick_in = exp_tick;
        pcnt = (m_n - 1) % (1 << PWM_W);
        for (int c = 0; c < N_CH; c++) begin
          h = (m_half[c] == 0) ? 1 : m_half[c];
          case (m_mode[c])
            1:       exp_led[c] = 1'b1;
            2:       exp_led[c] = ((m_ticks[c] / h) % 2) == 0;
            3:       exp_led[c] = pcnt < m_duty[c];
            default: exp_led[c] = 1'b0;
          endcase
          if (cfg.CFG_WE && int'(cfg.CFG_CH) == c) begin
            m_mode[c]  = int'(cfg.CFG_MODE);
            m_half[c]  = int'(cfg.CFG_HALF);
            m_duty[c]  = int'(cfg.CFG_DUTY);
            m_ticks[c] = 0;
          end else if (tick_in && m_mode[c] == 2) begin
            m_ticks[c]++;
          end
        end
        exp_tick = (m_n % DIV) == (DIV - 1);
      end
    end
  end

  always @(negedge CLK) begin
    vectors++;
    if (LED !== exp_led || TICK !== exp_tick) begin
      errs++;
      $display("FAIL model t=%0t: LED got %b want %b, TICK got %b want %b",
               $time, LED, exp_led, TICK, exp_tick);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int ch, input int mode, input int half, input int duty);
    cfg.CFG_CH   = CH_W'(ch);
    cfg.CFG_MODE = 2'(mode);
    cfg.CFG_HALF = PER_W'(half);
    cfg.CFG_DUTY = PWM_W'(duty);
    cfg.CFG_WE   = 1'b1;
    @(negedge CLK);
    cfg.CFG_WE   = 1'b0;
  endtask

  task automatic count_high(input int ch, input int len, output int hi);
    hi = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge CLK);
      if (LED[ch]) hi++;
    end
  endtask

  initial begin
    int hi, first, ticks;
    bit found;
    cfg.CFG_WE = 1'b0; cfg.CFG_CH = '0; cfg.CFG_MODE = '0;
    cfg.CFG_HALF = '0; cfg.CFG_DUTY = '0;

    // Reset and tick
    repeat (3) @(negedge CLK);
    chk("reset_led", int'(LED), 0);
    chk("reset_tick", int'(TICK), 0);
    RST = 1'b0;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (TICK && first < 0) first = k;
    end
    chk("first_tick_edge", first, 9);
    ticks = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (TICK) ticks++;
    end
    chk("ticks_per_100", ticks, 10);

    // BLINK ch0 half=3: 60-cycle period, 50% duty
    wr(0, 2, 3, 0);
    @(negedge CLK);
    chk("blink_first_on", int'(LED[0]), 1);
    repeat (60) @(negedge CLK);
    count_high(0, 300, hi);
    chk("blink_5_periods", hi, 150);

    // half=0 written on a tick edge
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge CLK);
      if (TICK) found = 1;
    end
    chk("tick_found", int'(found), 1);
    wr(1, 2, 0, 0);
    @(negedge CLK);
    chk("collide_phase_on", int'(LED[1]), 1);
    count_high(1, 9, hi);
    chk("collide_first_span", hi, 9);
    @(negedge CLK);
    chk("collide_toggle", int'(LED[1]), 0);
    count_high(1, 40, hi);
    chk("half0_period20", hi, 20);

    // PWM ch2
    wr(2, 3, 0, 5);
    @(negedge CLK);
    count_high(2, 32, hi);
    chk("pwm_duty5", hi, 10);
    wr(2, 3, 0, 0);
    @(negedge CLK);
    count_high(2, 16, hi);
    chk("pwm_duty0", hi, 0);
    wr(2, 3, 0, 15);
    @(negedge CLK);
    count_high(2, 16, hi);
    chk("pwm_duty15", hi, 15);
    wr(2, 0, 0, 0);

    // Isolation and out-of-range write
    wr(3, 1, 0, 0);
    chk("on_not_yet", int'(LED[3]), 0);
    @(negedge CLK);
    chk("on_next_edge", int'(LED[3]), 1);
    wr(4, 1, 1, 15);
    count_high(0, 60, hi);
    chk("ch0_unaffected", hi, 30);

    // Async reset while LED = 1011
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge CLK);
      if (LED == 4'b1011) found = 1;
    end
    chk("led_1011_seen", int'(found), 1);
    #2 RST = 1'b1;
    #1;
    chk("async_led", int'(LED), 0);
    chk("async_tick", int'(TICK), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (LED != '0) hi++;
    end
    chk("all_off_after_reset", hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
